// File: rtl/tt_and_tester_pkg.sv
// Shared types and constants for the 4-bit AND tester.
// Ports: none (package only).
// Holds the FSM state enum, operand width, vector count and error ceiling.
package tt_and_tester_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int W       = 4;
  localparam int NVEC    = 256;
  localparam int ERR_MAX = 31;

endpackage

// File: rtl/and_tester_checker.sv
// Result checker: delays golden A&B, the internal result and a valid bit by
// LAT stages, compares against the selected result and counts mismatches.
// Ports: clk/rst_n/en clock, reset, freeze; clr clears count and valid slots;
// vld/a/b issued operand; fault/mode run config; ext_res pin result; err count.
module and_tester_checker
  import tt_and_tester_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic         vld,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         fault,
  input  logic         mode,
  input  logic [W-1:0] ext_res,
  output logic [4:0]   err
);

  logic [W-1:0]   exp_pipe [LAT];
  logic [W-1:0]   res_pipe [LAT];
  logic [LAT-1:0] vld_pipe;

  logic [W-1:0] golden;
  logic [W-1:0] int_res;
  logic [W-1:0] dut_res;
  logic         mismatch;

  assign golden = a & b;

  // Fault injection corrupts only the all-ones operand pair, bit 0.
  assign int_res = golden ^ {{(W-1){1'b0}}, fault && (a == '1) && (b == '1)};

  // External results arrive already LAT cycles late, so they are used live.
  assign dut_res  = mode ? ext_res : res_pipe[LAT-1];
  assign mismatch = vld_pipe[LAT-1] && (exp_pipe[LAT-1] != dut_res);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        exp_pipe[i] <= '0;
        res_pipe[i] <= '0;
      end
      vld_pipe <= '0;
      err      <= '0;
    end else if (en) begin
      exp_pipe[0] <= golden;
      res_pipe[0] <= int_res;
      vld_pipe[0] <= vld && !clr;
      for (int i = 1; i < LAT; i++) begin
        exp_pipe[i] <= exp_pipe[i-1];
        res_pipe[i] <= res_pipe[i-1];
        vld_pipe[i] <= vld_pipe[i-1] && !clr;
      end
      if (clr) begin
        err <= '0;
      end else if (mismatch && (err != 5'(ERR_MAX))) begin
        err <= err + 5'd1;
      end
    end
  end

endmodule

// File: rtl/tt_um_and_tester.sv
// Tiny Tapeout on-chip tester for a 4-bit AND design: sweeps all 256 operand
// pairs, checks results (internal loopback or external pins) after LAT cycles.
// Ports: ui_in {res[3:0],-,fault,mode,start}; uo_out {err[4:0],pass,done,busy};
// uio_out {A,B}; uio_oe driven only while busy in external mode; uio_in unused.
module tt_um_and_tester
  import tt_and_tester_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam logic [7:0] LAST_VEC = 8'(NVEC - 1);
  localparam logic [1:0] LAT_LAST = 2'(LAT - 1);

  state_t     state, state_d;
  logic [1:0] sync_q;
  logic       sync_d1;
  logic       trig;
  logic [7:0] v;
  logic [1:0] dcnt;
  logic       mode_q;
  logic       fault_q;
  logic [4:0] err;
  logic       start_run;
  logic       busy;
  logic       done;
  logic       pass;

  logic unused_pins;
  assign unused_pins = ^{uio_in, ui_in[3]};

  // Trigger only from a resting state; starts during RUN/DRAIN are dropped.
  assign start_run = trig && ((state == IDLE) || (state == DONE));

  always_comb begin
    state_d = state;
    busy    = 1'b0;
    done    = 1'b0;
    uio_out = 8'h00;
    case (state)
      IDLE: begin
        if (trig) state_d = RUN;
      end
      RUN: begin
        busy    = 1'b1;
        uio_out = v;
        if (v == LAST_VEC) state_d = DRAIN;
      end
      DRAIN: begin
        busy    = 1'b1;
        uio_out = v;
        if (dcnt == LAT_LAST) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        uio_out = v;
        if (trig) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sync_q  <= '0;
      sync_d1 <= 1'b0;
      trig    <= 1'b0;
      v       <= '0;
      dcnt    <= '0;
      mode_q  <= 1'b0;
      fault_q <= 1'b0;
    end else if (ena) begin
      // Two-flop synchronizer, then a registered rising-edge detect.
      sync_q  <= {sync_q[0], ui_in[0]};
      sync_d1 <= sync_q[1];
      trig    <= sync_q[1] && !sync_d1;
      state   <= state_d;
      if (start_run) begin
        v       <= '0;
        dcnt    <= '0;
        mode_q  <= ui_in[1];
        fault_q <= ui_in[2];
      end else begin
        // v parks at the last vector so DRAIN/DONE keep showing 8'hFF.
        if ((state == RUN) && (v != LAST_VEC)) v <= v + 8'd1;
        if (state == DRAIN) dcnt <= dcnt + 2'd1;
      end
    end
  end

  and_tester_checker #(.LAT(LAT)) u_checker (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (ena),
    .clr     (start_run),
    .vld     (state == RUN),
    .a       (v[7:4]),
    .b       (v[3:0]),
    .fault   (fault_q),
    .mode    (mode_q),
    .ext_res (ui_in[7:4]),
    .err     (err)
  );

  assign pass   = done && (err == 5'd0);
  assign uo_out = {err, pass, done, busy};
  assign uio_oe = (busy && mode_q) ? 8'hFF : 8'h00;

endmodule

// File: tb/tb_tt_um_and_tester.sv
module tb_tt_um_and_tester;

  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic       fault = 1'b0;
  logic       ext_force = 1'b1;
  logic [3:0] model_res = 4'h0;
  logic       zero_model = 1'b0;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int total = 0;
  int bad = 0;

  // busy-cycle monitor state
  logic       counting = 1'b0;
  logic [7:0] exp_oe = 8'h00;
  int         busy_cnt = 0;
  int         oe_bad = 0;

  logic [7:0] h [4];
  logic [7:0] ref_uo;

  assign ui_in  = {(ext_force ? 4'hF : model_res), 1'b0, fault, mode, start};
  assign uio_in = 8'h5A;

  always #5 clk = ~clk;

  tt_um_and_tester #(.LAT(LAT)) dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  // External user-design model: returns A&B of the operand driven LAT cycles ago.
  always @(negedge clk) begin
    if (rst_n && ena) begin
      h[3] = h[2];
      h[2] = h[1];
      h[1] = h[0];
      h[0] = uio_out;
      model_res = zero_model ? 4'h0 : (h[LAT][7:4] & h[LAT][3:0]);
    end
  end

  always @(negedge clk) begin
    if (counting && uo_out[0]) begin
      busy_cnt = busy_cnt + 1;
      if (uio_oe !== exp_oe) oe_bad = oe_bad + 1;
    end
  end

  // Stimulus helper: launches one run and waits for done (bounded).
  task automatic do_run(input logic m, input logic f, input int drop_at,
                        input int retrig_at, output int cyc, output int oeb,
                        output logic [7:0] res);
    bit finished = 0;
    bit dropped = 0;
    bit retrigged = 0;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    mode = m;
    fault = f;
    exp_oe = m ? 8'hFF : 8'h00;
    busy_cnt = 0;
    oe_bad = 0;
    counting = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 800 && !finished; i++) begin
      @(negedge clk);
      if (busy_cnt > 0 && uo_out[1]) begin
        finished = 1;
      end else if (drop_at > 0 && !dropped && busy_cnt >= drop_at) begin
        dropped = 1;
        @(posedge clk); #1 ena = 1'b0;
        repeat (20) @(posedge clk);
        #1 ena = 1'b1;
      end else if (retrig_at > 0 && !retrigged && busy_cnt >= retrig_at) begin
        retrigged = 1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 start = 1'b1;
      end
    end
    counting = 1'b0;
    cyc = busy_cnt;
    oeb = oe_bad;
    res = uo_out;
  endtask

  task automatic test_reset();
    bit stable = 1;
    rst_n = 1'b0;
    ext_force = 1'b1;
    start = 1'b0;
    mode = 1'b1;
    fault = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (uo_out !== 8'h00) begin bad++; $display("FAIL reset_uo_out got=%h want=00", uo_out); end
    total++; if (uio_oe !== 8'h00) begin bad++; $display("FAIL reset_uio_oe got=%h want=00", uio_oe); end
    total++; if (uio_out !== 8'h00) begin bad++; $display("FAIL reset_uio_out got=%h want=00", uio_out); end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (uo_out !== 8'h00 || uio_oe !== 8'h00 || uio_out !== 8'h00) stable = 0;
    end
    total++; if (!stable) begin bad++; $display("FAIL idle_stable got uo=%h oe=%h out=%h want all 00", uo_out, uio_oe, uio_out); end
    mode = 1'b0;
    fault = 1'b0;
    ext_force = 1'b0;
  endtask

  task automatic test_internal();
    int cyc, oeb;
    logic [7:0] res;
    do_run(1'b0, 1'b0, 0, 0, cyc, oeb, res);
    ref_uo = res;
    total++; if (cyc != 256 + LAT) begin bad++; $display("FAIL int_busy_len got=%0d want=%0d", cyc, 256 + LAT); end
    total++; if (res !== 8'h06) begin bad++; $display("FAIL int_result got=%h want=06", res); end
    total++; if (oeb != 0) begin bad++; $display("FAIL int_oe got=%0d bad cycles want=0", oeb); end
    total++; if (uio_out !== 8'hFF) begin bad++; $display("FAIL done_uio_out got=%h want=ff", uio_out); end
  endtask

  task automatic test_restart();
    int cyc, oeb;
    logic [7:0] res;
    do_run(1'b0, 1'b0, 0, 0, cyc, oeb, res);
    total++; if (cyc != 256 + LAT) begin bad++; $display("FAIL restart_busy_len got=%0d want=%0d", cyc, 256 + LAT); end
    total++; if (res !== 8'h06) begin bad++; $display("FAIL restart_result got=%h want=06 (first run %h)", res, ref_uo); end
  endtask

  task automatic test_fault();
    int cyc, oeb;
    logic [7:0] res;
    do_run(1'b0, 1'b1, 0, 0, cyc, oeb, res);
    total++; if (cyc != 256 + LAT) begin bad++; $display("FAIL fault_busy_len got=%0d want=%0d", cyc, 256 + LAT); end
    total++; if (res !== 8'h0A) begin bad++; $display("FAIL fault_result got=%h want=0a", res); end
  endtask

  task automatic test_external();
    int cyc, oeb;
    logic [7:0] res;
    zero_model = 1'b0;
    do_run(1'b1, 1'b0, 0, 0, cyc, oeb, res);
    total++; if (cyc != 256 + LAT) begin bad++; $display("FAIL ext_busy_len got=%0d want=%0d", cyc, 256 + LAT); end
    total++; if (res !== 8'h06) begin bad++; $display("FAIL ext_result got=%h want=06", res); end
    total++; if (oeb != 0) begin bad++; $display("FAIL ext_oe got=%0d bad cycles want=0", oeb); end
    total++; if (uio_oe !== 8'h00) begin bad++; $display("FAIL ext_done_oe got=%h want=00", uio_oe); end
  endtask

  task automatic test_ext_zero();
    int cyc, oeb;
    logic [7:0] res;
    zero_model = 1'b1;
    do_run(1'b1, 1'b0, 0, 0, cyc, oeb, res);
    zero_model = 1'b0;
    total++; if (cyc != 256 + LAT) begin bad++; $display("FAIL zero_busy_len got=%0d want=%0d", cyc, 256 + LAT); end
    total++; if (res !== 8'hFA) begin bad++; $display("FAIL zero_result got=%h want=fa", res); end
  endtask

  task automatic test_ena_drop();
    int cyc, oeb;
    logic [7:0] res;
    do_run(1'b0, 1'b0, 100, 0, cyc, oeb, res);
    total++; if (cyc != 256 + LAT + 20) begin bad++; $display("FAIL ena_busy_len got=%0d want=%0d", cyc, 256 + LAT + 20); end
    total++; if (res !== 8'h06) begin bad++; $display("FAIL ena_result got=%h want=06", res); end
  endtask

  task automatic test_retrigger();
    int cyc, oeb;
    logic [7:0] res;
    do_run(1'b0, 1'b1, 0, 60, cyc, oeb, res);
    total++; if (cyc != 256 + LAT) begin bad++; $display("FAIL retrig_busy_len got=%0d want=%0d", cyc, 256 + LAT); end
    total++; if (res !== 8'h0A) begin bad++; $display("FAIL retrig_result got=%h want=0a", res); end
  endtask

  task automatic test_reset_mid_run();
    bit found = 0;
    bit stable = 1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    mode = 1'b1;
    fault = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (uo_out[0] && uio_out == 8'd100) found = 1;
    end
    total++; if (!found) begin bad++; $display("FAIL midrun_reach_v100 got=timeout want=v==100"); end
    total++; if (uio_oe !== 8'hFF) begin bad++; $display("FAIL midrun_oe_before got=%h want=ff", uio_oe); end
    rst_n = 1'b0;
    #1;
    total++; if (uo_out !== 8'h00) begin bad++; $display("FAIL midrun_uo_out got=%h want=00", uo_out); end
    total++; if (uio_out !== 8'h00) begin bad++; $display("FAIL midrun_uio_out got=%h want=00", uio_out); end
    total++; if (uio_oe !== 8'h00) begin bad++; $display("FAIL midrun_uio_oe got=%h want=00", uio_oe); end
    start = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'h00) stable = 0;
    end
    total++; if (!stable) begin bad++; $display("FAIL midrun_after_release got uo=%h out=%h oe=%h want all 00", uo_out, uio_out, uio_oe); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) h[i] = 8'h00;
    test_reset();
    test_internal();
    test_restart();
    test_fault();
    test_external();
    test_ext_zero();
    test_ena_drop();
    test_retrigger();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tt_um_and_tester.md
# tt_um_and_tester

On-chip tester for a 4-bit bitwise-AND user design. It is the driving and checking end of the same pin interface: it generates all 256 operand pairs, presents them on the bidirectional pins, and compares returned results against a golden A&B. It also has an internal loopback mode and reports busy/done/pass and a saturating error count on the dedicated outputs. It uses the standard Tiny Tapeout user-module port set.

## Interface
- LAT, default 2: cycles from operand drive to result sample in both modes; legal range 1..3.
- clk  in  1  sole clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low; clears all state.
- ena  in  1  design enable; when low, all state holds (freeze) and outputs hold.
- ui_in  in  8  [0] start; [1] mode (0 internal, 1 external); [2] fault-inject (internal mode only); [3] unused; [7:4] external result nibble.
- uo_out  out  8  [0] busy; [1] done; [2] pass; [7:3] error count (0..31, saturating).
- uio_in  in  8  unused, ignored.
- uio_out  out  8  {A[3:0], B[3:0]} current operand vector.
- uio_oe  out  8  8'hFF while busy in external mode, else 8'h00.

## Operation
- start passes through a 2-flop synchronizer; a rising edge of the synchronized start is the trigger. mode and fault-inject are sampled at the trigger and held for the run.
- The FSM has four states: IDLE, RUN, DRAIN and DONE.
- IDLE → RUN on trigger: clear vector counter, error count and done.
- RUN: an 8-bit vector counter v drives {A,B}=v, incrementing each enabled cycle, 0..255. After v=255 is issued, go to DRAIN.
- DRAIN: stay exactly LAT cycles so the last vector is checked, then go to DONE.
- DONE: done=1 and pass=(err==0). Hold until the next trigger, which re-enters RUN with cleared counters. DONE → RUN needs start to go low and then high again.
- A trigger during RUN/DRAIN is ignored.
- Golden: exp = A & B, delayed LAT cycles alongside the operands.
- Internal mode: the result is A&B through the same LAT-stage delay. With fault-inject set, bit 0 of the result is inverted when A==4'hF and B==4'hF.
- External mode: the result is ui_in[7:4] sampled LAT cycles after the operand was driven. It is treated as synchronous to clk and is not synchronized.
- Compare occurs only for valid pipeline slots (LAT-deep valid shift register). A mismatch increments err, saturating at 31.
- Outputs: busy = RUN or DRAIN. uio_out holds the last vector (8'hFF) in DRAIN and DONE, and 8'h00 in IDLE.

## Timing
- Reset values: uo_out=0, uio_out=0, uio_oe=0, FSM=IDLE, all counters 0, valid pipeline empty.
- Start latency: the trigger is recognized 2 enabled cycles after start rises at the pin, plus 1 cycle for edge detect. busy asserts the following cycle.
- Run length: 256 RUN cycles + LAT DRAIN cycles. done asserts on the first DONE cycle.
- ena low: no state changes, including the synchronizer, counters and pipeline. Resuming continues exactly where it froze.
- rst_n asserted mid-run: immediate return to reset values. No partial result is retained.
- Error-count saturation: a mismatch at err=31 leaves it at 31; pass stays 0.

## Structure
- Package tt_and_tester_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - localparam W=4;
  - localparam NVEC=256;
  - localparam ERR_MAX=31.
- One natural sub-module, and_tester_checker: LAT-deep delay of expected value and valid bit, result compare, and the saturating error counter.
- Top-level tt_um_and_tester holds the synchronizer, the FSM, the vector counter, mode muxing and output packing.

## Test plan
- Reset: hold rst_n=0 with arbitrary ui_in → uo_out=0, uio_oe=0 and uio_out=0; release and idle 10 cycles → unchanged.
- Internal, no fault, LAT=2: pulse start with mode=0 → busy for 258 cycles, then done=1, pass=1, err=0 (uo_out=8'h06).
- Internal, fault-inject=1 → done=1, pass=0, err=1 (uo_out=8'h0A).
- External with bench model returning A&B delayed LAT cycles → uio_oe=8'hFF while busy, done with pass=1, err=0. With the model returning a constant 0 → 175 mismatches expected, err saturates at 31, pass=0 (uo_out=8'hFA).
- Disturbances:
  - Drop ena for 20 cycles mid-RUN → run completes with identical result, with total busy extended by 20.
  - Retrigger start during RUN → ignored.
  - Assert rst_n at v=100 → immediate reset values.
- Restart from DONE: lower and raise start → counters clear, a new 258-cycle run occurs, and the results match the first run.
